// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle RV32I-subset control FSM
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes halt instead of retiring as NOP.
module mc_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [3:0]  alu_ctl,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b101
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;

  state_t     cur, nxt;
  logic       retire;
  logic [3:0] alu_op;
  logic       unused_instr;

  wire [6:0] opcode = instr[6:0];
  wire [2:0] funct3 = instr[14:12];
  wire [6:0] funct7 = instr[31:25];

  wire is_r  = (opcode == 7'b0110011);
  wire is_i  = (opcode == 7'b0010011);
  wire is_ld = (opcode == 7'b0000011);
  wire is_st = (opcode == 7'b0100011);
  wire is_br = (opcode == 7'b1100011);

  assign unused_instr = ^{instr[24:15], instr[11:7]};
  assign state        = cur;

  // Address generation uses ADD, compare uses SUB; SUB only exists for R-type.
  always_comb begin
    alu_op = ALU_ADD;
    if (is_br) begin
      alu_op = ALU_SUB;
    end else if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_op = (is_r && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_op = ALU_AND;
        3'b110:  alu_op = ALU_OR;
        3'b100:  alu_op = ALU_XOR;
        3'b001:  alu_op = ALU_SLL;
        3'b101:  alu_op = ALU_SRL;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_FETCH;
      instret <= 32'd0;
    end else begin
      cur <= nxt;
      if (retire) instret <= instret + 32'd1;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (cur == S_DECODE && !(is_r || is_i || is_ld || is_st || is_br)) begin
      illegal <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_ctl    = ALU_ADD;
    retire     = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_r || is_i || is_ld || is_st || is_br) begin
          nxt = S_EXEC;
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          nxt = S_HALT;
`else
          nxt    = S_FETCH;
          retire = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        alu_ctl = alu_op;
        alu_src = is_i || is_ld || is_st;
        if (is_br) begin
          pc_src   = 1'b1;
          pc_write = zero;
          retire   = 1'b1;
          nxt      = S_FETCH;
        end else if (is_ld || is_st) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_st;
        if (mem_ready) begin
          if (is_st) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
    // Strobes must drop the moment reset asserts, even mid-access.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      alu_ctl    = ALU_ADD;
      retire     = 1'b0;
    end
  end

endmodule
